// File: rtl/rom_streamer_pkg.sv
// rtl/rom_streamer_pkg.sv - shared types and constants for the ROM streamer
// Contents: FSM state encoding, output buffer depth, buffer entry layout.
// Optional feature macro used by the streamer: ROM_STREAMER_LOOP_EN.
package rom_streamer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Two entries: one word being presented plus one word landing from the ROM,
   // which is what sustains one word per cycle with a 1-cycle-latency ROM.
   localparam int BUF_DEPTH = 2;

   // Entry layout for the default 8-bit ROM; the buffer stores the same
   // {last, data} packing generically as a DW+1 bit vector.
   localparam int ENTRY_DW = 8;

   typedef struct packed {
      logic                last;
      logic [ENTRY_DW-1:0] data;
   } buf_entry_t;

endpackage

// File: rtl/rom_stream_buf.sv
// rtl/rom_stream_buf.sv - 2-entry valid/ready FIFO with flush and occupancy
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of all entries (wins over write/read)
//   wr_en, wr_data    write side; writes are dropped when full and not reading
//   rd_data, rd_valid head entry and its valid flag
//   rd_ready          consumer accepts the head entry
//   occ               current number of stored entries
module rom_stream_buf
   import rom_streamer_pkg::*;
#(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   output logic [W-1:0] rd_data,
   output logic         rd_valid,
   input  logic         rd_ready,
   output logic [1:0]   occ
);

   logic [W-1:0] mem [BUF_DEPTH];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;
   logic         do_rd;
   logic         do_wr;

   assign rd_valid = (count != 2'd0);
   assign rd_data  = mem[rd_ptr];
   assign occ      = count;
   assign do_rd    = rd_valid && rd_ready;
   // When full, a write may only land in the slot being freed by this cycle's read.
   assign do_wr    = wr_en && ((count != 2'(BUF_DEPTH)) || do_rd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_wr) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_rd) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_wr} - {1'b0, do_rd};
      end
   end

endmodule

// File: rtl/rom_streamer.sv
// rtl/rom_streamer.sv - walks a ROM address range and streams the words out
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   start, start_addr, len     transfer request (sampled in IDLE); len=0 -> no data
//   abort                      cancel of the running transfer, no done pulse
//   busy, done                 transfer in progress / one-cycle completion pulse
//   rom_addr, rom_data         address to and data from a 1-cycle-latency ROM
//   out_data, out_valid,
//   out_ready, out_last        output stream, last marks the final word
// Optional feature: ROM_STREAMER_LOOP_EN repeats the range until aborted.
module rom_streamer
   import rom_streamer_pkg::*;
#(
   parameter int AW = 5,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] start_addr,
   input  logic [AW:0]   len,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_last
);

   state_t        state_q;
   state_t        state_d;
   logic [AW-1:0] addr_q;
   logic [AW:0]   remaining_q;
   logic          inflight_q;
   logic          inflight_last_q;
`ifdef ROM_STREAMER_LOOP_EN
   logic [AW-1:0] base_addr_q;
   logic [AW:0]   base_len_q;
`endif

   logic          running;
   logic          flush;
   logic          pop;
   logic [2:0]    pending;
   logic          issue;
   logic          last_issue;
   logic [1:0]    occ;
   logic [DW:0]   head;

   assign rom_addr   = addr_q;
   assign running    = (state_q == RUN) || (state_q == DRAIN);
   assign flush      = abort && running;
   assign pop        = out_valid && out_ready;
   // Words held or on their way from the ROM after this cycle; issuing only
   // while this is below two guarantees the buffer can never overflow.
   assign pending    = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
   assign issue      = (state_q == RUN) && !abort && (pending < 3'd2);
   assign last_issue = issue && (remaining_q == (AW+1)'(1));

   rom_stream_buf #(.W(DW + 1)) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .wr_en    (inflight_q && !flush),
      .wr_data  ({inflight_last_q, rom_data}),
      .rd_data  (head),
      .rd_valid (out_valid),
      .rd_ready (out_ready),
      .occ      (occ)
   );

   assign out_data = head[DW-1:0];
   assign out_last = head[DW];

   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (abort) begin
               state_d = IDLE;
            end else if (last_issue) begin
`ifdef ROM_STREAMER_LOOP_EN
               state_d = RUN;
`else
               state_d = DRAIN;
`endif
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (abort) begin
               state_d = IDLE;
            end else if (pop && out_last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         remaining_q     <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
`ifdef ROM_STREAMER_LOOP_EN
         base_addr_q     <= '0;
         base_len_q      <= '0;
`endif
      end else begin
         state_q         <= state_d;
         inflight_q      <= issue;
         inflight_last_q <= last_issue;
         if ((state_q == IDLE) && start && (len != '0)) begin
            addr_q      <= start_addr;
            remaining_q <= len;
`ifdef ROM_STREAMER_LOOP_EN
            base_addr_q <= start_addr;
            base_len_q  <= len;
`endif
         end else if (issue) begin
`ifdef ROM_STREAMER_LOOP_EN
            if (last_issue) begin
               addr_q      <= base_addr_q;
               remaining_q <= base_len_q;
            end else begin
               addr_q      <= addr_q + AW'(1);
               remaining_q <= remaining_q - (AW+1)'(1);
            end
`else
            addr_q      <= addr_q + AW'(1);
            remaining_q <= remaining_q - (AW+1)'(1);
`endif
         end
      end
   end

endmodule
